// File: rtl/iob_ram_2p_clr.sv
// Single-clock two-port RAM (one write, one read port) that zero-sweeps its contents after reset
// and on clear, with byte strobes, optional output register, read-valid and write forwarding.
module iob_ram_2p_clr #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned OUT_REG = 0,
    parameter int unsigned BYPASS  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                busy,
    input  logic                w_en,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic                r_en,
    input  logic [ADDR_W-1:0]   r_addr,
    output logic [DATA_W-1:0]   r_data,
    output logic                r_valid
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned StrbW = DATA_W / 8;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [StrbW-1:0]  mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] rd_word;

    logic              p_valid_q, p_valid_d;
    logic [DATA_W-1:0] p_data_q, p_data_d;
    logic              r_valid_q, r_valid_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;

    assign busy    = (state_q == StInit);
    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;

    // clr wins over any access presented in the same cycle
    assign wr_acc = !busy && !clr && w_en;
    assign rd_acc = !busy && !clr && r_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (&cnt_q) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (clr) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The sweep owns the write port while busy
    always_comb begin
        mem_we    = '0;
        mem_addr  = w_addr;
        mem_wdata = w_data;
        if (busy) begin
            mem_we    = '1;
            mem_addr  = cnt_q;
            mem_wdata = '0;
        end else if (wr_acc) begin
            mem_we = w_strb;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < StrbW; k++) begin
            if (mem_we[k]) begin
                mem_q[mem_addr][k*8 +: 8] <= mem_wdata[k*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem_q[r_addr];
        if (BYPASS != 0 && wr_acc && (w_addr == r_addr)) begin
            for (int k = 0; k < StrbW; k++) begin
                if (w_strb[k]) begin
                    rd_word[k*8 +: 8] = w_data[k*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        p_valid_d = rd_acc;
        p_data_d  = rd_acc ? rd_word : p_data_q;
        if (OUT_REG != 0) begin
            r_valid_d = p_valid_q;
            r_data_d  = p_valid_q ? p_data_q : r_data_q;
        end else begin
            r_valid_d = rd_acc;
            r_data_d  = rd_acc ? rd_word : r_data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid_q <= 1'b0;
            p_data_q  <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            p_valid_q <= p_valid_d;
            p_data_q  <= p_data_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
        end
    end

endmodule

// File: tb/tb_iob_ram_2p_clr.sv
// Bench for iob_ram_2p_clr: drives one stimulus stream into an OUT_REG=0/BYPASS=1 instance and
// an OUT_REG=1/BYPASS=0 instance, checking each against hand-computed expectations.
module tb_iob_ram_2p_clr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        w_en = 1'b0;
    logic [3:0]  w_strb = '0;
    logic [3:0]  w_addr = '0;
    logic [31:0] w_data = '0;
    logic        r_en = 1'b0;
    logic [3:0]  r_addr = '0;
    logic        busy0, busy1, rv0, rv1;
    logic [31:0] rd0, rd1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iob_ram_2p_clr #(.DATA_W(32), .ADDR_W(4), .OUT_REG(0), .BYPASS(1)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy0),
        .w_en(w_en), .w_strb(w_strb), .w_addr(w_addr), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(rd0), .r_valid(rv0)
    );

    iob_ram_2p_clr #(.DATA_W(32), .ADDR_W(4), .OUT_REG(1), .BYPASS(0)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy1),
        .w_en(w_en), .w_strb(w_strb), .w_addr(w_addr), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(rd1), .r_valid(rv1)
    );

    typedef struct {
        logic        w_en;
        logic [3:0]  strb;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic        r_en;
        logic [3:0]  raddr;
        logic        ev0;
        logic [31:0] ed0;
        logic        ev1;
        logic [31:0] ed1;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] m_last0 = '0;
    logic [31:0] m_last1 = '0;
    logic        m_pend_v = 1'b0;
    logic [31:0] m_pend_d = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // e0/e1: read result expected from the forwarding and non-forwarding instance
    task automatic push(input logic we, input logic [3:0] st, input logic [3:0] wa,
                        input logic [31:0] wd, input logic re, input logic [3:0] ra,
                        input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.w_en = we; v.strb = st; v.waddr = wa; v.wdata = wd; v.r_en = re; v.raddr = ra;
        v.ev0 = re;
        if (re) m_last0 = e0;
        v.ed0 = m_last0;
        v.ev1 = m_pend_v;
        if (m_pend_v) m_last1 = m_pend_d;
        v.ed1 = m_last1;
        m_pend_v = re;
        m_pend_d = e1;
        vecs.push_back(v);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] st);
        push(1'b1, st, a, d, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        push(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a, e, e);
    endtask

    task automatic idle();
        push(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic wait_sweep(input string nm);
        int n;
        n = 0;
        do begin
            step();
            n++;
            chk({nm, "_rv0_quiet"}, {31'b0, rv0}, 32'h0);
            chk({nm, "_rv1_quiet"}, {31'b0, rv1}, 32'h0);
        end while (busy0 && n < 40);
        chk({nm, "_busy_edges"}, n, 32'd16);
        chk({nm, "_busy1_low"}, {31'b0, busy1}, 32'h0);
    endtask

    task automatic read_all_zero(input string nm);
        for (int i = 0; i < 16; i++) begin
            r_en = 1'b1;
            r_addr = 4'(i);
            step();
            chk($sformatf("%s_rv0_%0d", nm, i), {31'b0, rv0}, 32'h1);
            chk($sformatf("%s_rd0_%0d", nm, i), rd0, 32'h0);
            chk($sformatf("%s_rv1_%0d", nm, i), {31'b0, rv1}, (i > 0) ? 32'h1 : 32'h0);
            if (i > 0) chk($sformatf("%s_rd1_%0d", nm, i), rd1, 32'h0);
        end
        r_en = 1'b0;
        step();
        chk({nm, "_rv0_tail"}, {31'b0, rv0}, 32'h0);
        chk({nm, "_rv1_tail"}, {31'b0, rv1}, 32'h1);
        chk({nm, "_rd1_tail"}, rd1, 32'h0);
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            w_en = 1'b1; w_strb = 4'hF; w_addr = 4'(i); w_data = base + 32'(i);
            step();
        end
        w_en = 1'b0;
    endtask

    initial begin
        // Vector table
        for (int i = 0; i < 16; i++) rd(4'(i), 32'h0);
        idle(); idle();
        for (int i = 0; i < 16; i++) wr(4'(i), 32'h20 + 32'(i), 4'hF);
        for (int i = 0; i < 16; i++) rd(4'(i), 32'h20 + 32'(i));
        idle(); idle();
        wr(4'd3, 32'hAABBCCDD, 4'hF);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd(4'd3, 32'hAA22CC44);
        wr(4'd3, 32'hFFFFFFFF, 4'h0);
        rd(4'd3, 32'hAA22CC44);
        wr(4'd5, 32'h0, 4'hF);
        push(1'b1, 4'hF, 4'd5, 32'h12345678, 1'b1, 4'd5, 32'h12345678, 32'h0);
        rd(4'd5, 32'h12345678);
        push(1'b1, 4'b0011, 4'd6, 32'hAABBCCDD, 1'b1, 4'd6, 32'h0000CCDD, 32'h26);
        rd(4'd6, 32'h0000CCDD);
        wr(4'd9, 32'h99, 4'hF);
        rd(4'd9, 32'h99);
        push(1'b1, 4'hF, 4'd10, 32'hA0A0, 1'b1, 4'd11, 32'h2B, 32'h2B);
        rd(4'd10, 32'hA0A0);
        idle(); idle();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy0", {31'b0, busy0}, 32'h1);
        chk("rst_busy1", {31'b0, busy1}, 32'h1);
        chk("rst_rv0", {31'b0, rv0}, 32'h0);
        chk("rst_rv1", {31'b0, rv1}, 32'h0);
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_rd1", rd1, 32'h0);
        rst = 1'b0;
        wait_sweep("init");

        foreach (vecs[i]) begin
            w_en = vecs[i].w_en; w_strb = vecs[i].strb; w_addr = vecs[i].waddr;
            w_data = vecs[i].wdata; r_en = vecs[i].r_en; r_addr = vecs[i].raddr;
            step();
            chk($sformatf("vec%0d_busy", i), {31'b0, busy0}, 32'h0);
            chk($sformatf("vec%0d_rv0", i), {31'b0, rv0}, {31'b0, vecs[i].ev0});
            chk($sformatf("vec%0d_rd0", i), rd0, vecs[i].ed0);
            chk($sformatf("vec%0d_rv1", i), {31'b0, rv1}, {31'b0, vecs[i].ev1});
            chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].ed1);
        end
        w_en = 1'b0; r_en = 1'b0;

        // clr with a read in flight in the registered instance; same-cycle accesses dropped
        r_en = 1'b1; r_addr = 4'd3;
        step();
        chk("pre_clr_rv0", {31'b0, rv0}, 32'h1);
        chk("pre_clr_rd0", rd0, 32'hAA22CC44);
        clr = 1'b1; w_en = 1'b1; w_strb = 4'hF; w_addr = 4'd7; w_data = 32'hDEADBEEF;
        r_addr = 4'd9;
        step();
        clr = 1'b0;
        chk("clr_busy0", {31'b0, busy0}, 32'h1);
        chk("clr_busy1", {31'b0, busy1}, 32'h1);
        chk("clr_rv0", {31'b0, rv0}, 32'h0);
        chk("clr_rd0_hold", rd0, 32'hAA22CC44);
        chk("clr_inflight_rv1", {31'b0, rv1}, 32'h1);
        chk("clr_inflight_rd1", rd1, 32'hAA22CC44);
        w_addr = 4'd2; w_data = 32'h5555; r_addr = 4'd3;
        wait_sweep("clr");
        w_en = 1'b0; r_en = 1'b0;
        read_all_zero("after_clr");

        // rst during an in-flight read discards it
        fill(32'hF0);
        r_en = 1'b1; r_addr = 4'd1;
        step();
        chk("mid_read_rv0", {31'b0, rv0}, 32'h1);
        chk("mid_read_rd0", rd0, 32'hF1);
        r_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'b0, busy0}, 32'h1);
        chk("async_rst_rd0", rd0, 32'h0);
        step();
        chk("async_rst_rv1", {31'b0, rv1}, 32'h0);
        chk("async_rst_rd1", rd1, 32'h0);
        rst = 1'b0;
        wait_sweep("rst_read");

        // rst at sweep cycle 8 restarts the sweep
        fill(32'h300);
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (8) step();
        chk("mid_sweep_busy", {31'b0, busy0}, 32'h1);
        rst = 1'b1;
        step();
        chk("mid_sweep_rd0", rd0, 32'h0);
        chk("mid_sweep_rd1", rd1, 32'h0);
        rst = 1'b0;
        wait_sweep("rst_sweep");
        read_all_zero("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_ram_2p_clr.md
# iob_ram_2p_clr

Single-clock two-port RAM (one write port, one read port) for IOb cores that need a memory with defined contents: all locations are swept to zero after reset and on a clear request. Adds byte-strobe writes, an optional output register stage, read-valid signalling, and configurable same-address read/write forwarding. Drop-in storage for FIFOs, buffers and register files inside single-clock cores.

## Interface
- DATA_W, 32, data width in bits; must be a multiple of 8
- ADDR_W, 6, address width; depth = 2**ADDR_W
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1)
- BYPASS, 1, 1 forwards same-cycle same-address write data to the read; 0 returns old data

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear request, sampled in RUN only
- busy  out  1  high while the zero sweep is in progress
- w_en  in  1  write enable
- w_strb  in  DATA_W/8  byte write strobes; byte k written when w_strb[k]=1
- w_addr  in  ADDR_W  write address
- w_data  in  DATA_W  write data
- r_en  in  1  read enable
- r_addr  in  ADDR_W  read address
- r_data  out  DATA_W  read data, registered, holds last value when no read completes
- r_valid  out  1  one-cycle pulse when r_data carries a newly completed read

## Operation
- FSM states: INIT (zero sweep), RUN.
- rst asserted: state=INIT, sweep counter=0, busy=1, r_data=0, r_valid=0, output pipeline cleared. Memory contents are not touched by rst itself; the sweep clears them.
- INIT: each edge writes 0 to address = counter (all bytes), counter+1. On the edge writing address 2**ADDR_W-1, state->RUN, busy->0. w_en, r_en, clr ignored while busy=1; no r_valid generated.
- RUN, clr=1: state->INIT, counter=0, busy=1 on that edge. clr has priority: w_en and r_en in the same cycle are dropped. In-flight OUT_REG read completes normally (r_valid still pulses).
- RUN write: w_en=1 writes bytes selected by w_strb at w_addr. w_strb=0 with w_en=1 is a no-op.
- RUN read: r_en=1 reads r_addr; result appears per Timing with r_valid=1.
- Same cycle, w_en=1, r_en=1, w_addr=r_addr: BYPASS=1 -> r_data bytes with w_strb[k]=1 take w_data, others take stored data; BYPASS=0 -> r_data is entirely the pre-write contents.
- Addresses wrap naturally in ADDR_W bits; no out-of-range condition.
- rst asserted mid-sweep or mid-read: sweep restarts from address 0, pending read discarded (no r_valid).

## Timing
- Sweep: busy high for exactly 2**ADDR_W rising edges after rst deasserts (or after the clr edge); first accepted access is at the edge after busy is sampled low.
- Read latency: OUT_REG=0 -> r_data/r_valid update at the edge after r_en is sampled (1 cycle); OUT_REG=1 -> 2 cycles. Back-to-back reads every cycle, one result per cycle.
- r_valid is 1 for exactly one cycle per accepted read; r_data unchanged when r_valid=0.
- Write visible to a read issued on the following edge (1-cycle write-to-read, no bypass needed).

## Test plan
- DATA_W=32, ADDR_W=4, OUT_REG=0: release rst -> busy=1 for 16 cycles then 0; read all 16 addresses -> r_data=0, r_valid pulses 16 times.
- Write addr i = 0x20+i for i=0..15 (w_strb=4'hF), read back 0..15 back-to-back -> r_data=0x20+i one cycle after each r_en; repeat with OUT_REG=1 -> 2-cycle latency.
- Write 0xAABBCCDD to addr 3, then 0x11223344 with w_strb=4'b0101 -> read addr 3 returns 0xAA22CC44.
- Same-cycle write 0x12345678 (w_strb=4'hF) and read at addr 5 holding 0x0 -> BYPASS=1 returns 0x12345678; BYPASS=0 returns 0x0, next read returns 0x12345678.
- In RUN pulse clr with w_en=1 to addr 7 -> write dropped, busy=1 for 16 cycles, all locations read 0; w_en/r_en during busy produce no write and no r_valid.
- Assert rst at sweep cycle 8 after filling memory -> sweep restarts at 0, busy 16 cycles after release, all locations 0, r_data=0.
